// File: rtl/bin_count_ctrl.sv
// rtl/bin_count_ctrl.sv - run/pause/step controller for the LED binary-number display
// Owns the tick prescaler, the 4-bit displayed count and the heartbeat toggle.
module bin_count_ctrl #(
    parameter int TICK_BASE = 200000000,
    parameter int PRE_W     = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_pulse,
    input  logic       stop_pulse,
    input  logic       step_pulse,
    input  logic       clear_pulse,
    input  logic       dir,
    input  logic [1:0] speed,
    output logic [3:0] num,
    output logic       tick,
    output logic       led_clk,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_STEP  = 2'b11
    } state_t;

    // One extra bit so TICK_BASE == 2^PRE_W still fits.
    localparam logic [PRE_W:0] BASE = (PRE_W+1)'(TICK_BASE);

    state_t           cur;
    logic [PRE_W-1:0] pre;
    logic [PRE_W:0]   period;
    logic [PRE_W:0]   period_m1;
    logic             terminal;
    logic [3:0]       num_next;

    // >= rather than == so a speed increase mid-count fires on the next edge.
    always_comb begin
        period    = BASE >> speed;
        period_m1 = period - (PRE_W+1)'(1);
        terminal  = ({1'b0, pre} >= period_m1);
        num_next  = dir ? (num + 4'd1) : (num - 4'd1);
    end

    assign state = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= S_IDLE;
            pre     <= '0;
            num     <= 4'd0;
            tick    <= 1'b0;
            led_clk <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clear_pulse) begin
                cur     <= S_IDLE;
                pre     <= '0;
                num     <= 4'd0;
                led_clk <= 1'b0;
            end else begin
                case (cur)
                    S_IDLE: begin
                        pre <= '0;
                        if (stop_pulse) begin
                            cur <= S_IDLE;
                        end else if (start_pulse) begin
                            cur <= S_RUN;
                        end else if (step_pulse) begin
                            num     <= num_next;
                            led_clk <= ~led_clk;
                            tick    <= 1'b1;
                            cur     <= S_STEP;
                        end
                    end
                    S_RUN: begin
                        if (stop_pulse) begin
                            cur <= S_PAUSE;
                        end else if (terminal) begin
                            pre     <= '0;
                            num     <= num_next;
                            led_clk <= ~led_clk;
                            tick    <= 1'b1;
                        end else begin
                            pre <= pre + PRE_W'(1);
                        end
                    end
                    S_PAUSE: begin
                        // Prescaler keeps its value so a resume finishes the interrupted period.
                        if (stop_pulse) begin
                            cur <= S_PAUSE;
                        end else if (start_pulse) begin
                            cur <= S_RUN;
                        end else if (step_pulse) begin
                            num     <= num_next;
                            led_clk <= ~led_clk;
                            tick    <= 1'b1;
                            cur     <= S_STEP;
                        end
                    end
                    S_STEP: begin
                        cur <= S_PAUSE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bin_count_ctrl.sv
// tb/tb_bin_count_ctrl.sv - self-checking bench for bin_count_ctrl
module tb_bin_count_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_pulse, stop_pulse, step_pulse, clear_pulse;
    logic       dir;
    logic [1:0] speed;
    logic [3:0] num;
    logic       tick;
    logic       led_clk;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic exp_led = 1'b0;

    typedef struct {
        int         edge_n;
        logic [3:0] num;
        logic       led;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string      name;
        logic [3:0] cmd;    // {clear, stop, start, step}
        logic       dir;
        logic [3:0] num;
        logic [1:0] st;
        logic       upd;
    } vec_t;
    vec_t vt[14];

    bin_count_ctrl #(.TICK_BASE(16), .PRE_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_pulse(start_pulse),
        .stop_pulse (stop_pulse),
        .step_pulse (step_pulse),
        .clear_pulse(clear_pulse),
        .dir        (dir),
        .speed      (speed),
        .num        (num),
        .tick       (tick),
        .led_clk    (led_clk),
        .state      (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_upd(input int e, input logic [3:0] n);
        exp_led = ~exp_led;
        sb.push_back('{e, n, exp_led});
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) step_edge();
    endtask

    // Every tick must match the next queued update: edge, value, heartbeat.
    always @(negedge clk) begin
        if (rst_n && tick === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected tick edge", cyc, -1);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("tick edge", cyc, x.edge_n);
                check("tick num", int'(num), int'(x.num));
                check("tick led_clk", int'(led_clk), int'(x.led));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t exceeded limit %0d", $time, 100000);
        $fatal(1);
    end

    initial begin
        int e0, s;

        vt[0]  = '{"pause step",        4'b0001, 1'b1, 4'd12, 2'b11, 1'b1};
        vt[1]  = '{"step in step",      4'b0001, 1'b1, 4'd12, 2'b10, 1'b0};
        vt[2]  = '{"pause idle",        4'b0000, 1'b1, 4'd12, 2'b10, 1'b0};
        vt[3]  = '{"second step",       4'b0001, 1'b1, 4'd13, 2'b11, 1'b1};
        vt[4]  = '{"back to pause",     4'b0000, 1'b1, 4'd13, 2'b10, 1'b0};
        vt[5]  = '{"stop in pause",     4'b0100, 1'b1, 4'd13, 2'b10, 1'b0};
        vt[6]  = '{"start over step",   4'b0011, 1'b1, 4'd13, 2'b01, 1'b0};
        vt[7]  = '{"stop over start",   4'b0111, 1'b1, 4'd13, 2'b10, 1'b0};
        vt[8]  = '{"clear pause",       4'b1000, 1'b1, 4'd0,  2'b00, 1'b0};
        vt[9]  = '{"stop in idle",      4'b0100, 1'b1, 4'd0,  2'b00, 1'b0};
        vt[10] = '{"idle step down",    4'b0001, 1'b0, 4'd15, 2'b11, 1'b1};
        vt[11] = '{"start in step",     4'b0010, 1'b0, 4'd15, 2'b10, 1'b0};
        vt[12] = '{"step down again",   4'b0001, 1'b0, 4'd14, 2'b11, 1'b1};
        vt[13] = '{"clear in step",     4'b1000, 1'b0, 4'd0,  2'b00, 1'b0};

        rst_n = 1'b0;
        {start_pulse, stop_pulse, step_pulse, clear_pulse} = 4'b0;
        dir = 1'b1;
        speed = 2'd0;
        repeat (2) step_edge();
        check("reset num", int'(num), 0);
        check("reset state", int'(state), 0);
        check("reset tick", int'(tick), 0);
        check("reset led_clk", int'(led_clk), 0);
        rst_n = 1'b1;
        step_edge();

        // Base rate: updates every 16 edges after start.
        e0 = cyc + 1;
        start_pulse = 1'b1;
        for (int k = 1; k <= 3; k++) expect_upd(e0 + 16*k, 4'(k));
        step_edge();
        start_pulse = 1'b0;
        check("run state", int'(state), 1);

        // Period 4, wrap up through 15 -> 0, then down 0 -> 15.
        wait_edge(e0 + 48);
        speed = 2'd2;
        for (int k = 1; k <= 13; k++) expect_upd(e0 + 48 + 4*k, 4'((3 + k) % 16));
        wait_edge(e0 + 100);
        check("wrap up num", int'(num), 0);
        dir = 1'b0;
        expect_upd(e0 + 104, 4'd15);
        wait_edge(e0 + 104);
        check("wrap down num", int'(num), 15);

        // Prescaler at 10, switch to period 2.
        speed = 2'd0;
        wait_edge(e0 + 114);
        speed = 2'd3;
        expect_upd(e0 + 115, 4'd14);
        expect_upd(e0 + 117, 4'd13);
        expect_upd(e0 + 119, 4'd12);
        wait_edge(e0 + 119);
        speed = 2'd0;

        // Stop on the terminal edge, then resume.
        wait_edge(e0 + 134);
        stop_pulse = 1'b1;
        step_edge();
        stop_pulse = 1'b0;
        check("stop terminal num", int'(num), 12);
        check("stop terminal state", int'(state), 2);
        check("stop terminal tick", int'(tick), 0);
        wait_edge(e0 + 137);
        start_pulse = 1'b1;
        expect_upd(e0 + 139, 4'd11);
        step_edge();
        start_pulse = 1'b0;
        check("resume state", int'(state), 1);
        check("resume num held", int'(num), 12);
        wait_edge(e0 + 139);
        check("resume num", int'(num), 11);
        stop_pulse = 1'b1;
        step_edge();
        stop_pulse = 1'b0;
        check("pause state", int'(state), 2);

        foreach (vt[i]) begin
            s = cyc + 1;
            {clear_pulse, stop_pulse, start_pulse, step_pulse} = vt[i].cmd;
            dir = vt[i].dir;
            if (vt[i].cmd[3]) exp_led = 1'b0;
            if (vt[i].upd) expect_upd(s, vt[i].num);
            step_edge();
            {clear_pulse, stop_pulse, start_pulse, step_pulse} = 4'b0;
            check({vt[i].name, " num"}, int'(num), int'(vt[i].num));
            check({vt[i].name, " state"}, int'(state), int'(vt[i].st));
        end
        check("clear led_clk", int'(led_clk), 0);

        // Count down to 9, then clear+stop+start together.
        dir = 1'b0;
        speed = 2'd3;
        s = cyc + 1;
        start_pulse = 1'b1;
        for (int k = 1; k <= 7; k++) expect_upd(s + 2*k, 4'(16 - k));
        step_edge();
        start_pulse = 1'b0;
        wait_edge(s + 14);
        check("pre-clear num", int'(num), 9);
        {clear_pulse, stop_pulse, start_pulse} = 3'b111;
        step_edge();
        {clear_pulse, stop_pulse, start_pulse} = 3'b000;
        exp_led = 1'b0;
        check("combo clear num", int'(num), 0);
        check("combo clear led_clk", int'(led_clk), 0);
        check("combo clear state", int'(state), 0);
        check("combo clear tick", int'(tick), 0);

        // Asynchronous reset between clock edges.
        step_edge();
        dir = 1'b1;
        s = cyc + 1;
        start_pulse = 1'b1;
        expect_upd(s + 2, 4'd1);
        step_edge();
        start_pulse = 1'b0;
        wait_edge(s + 3);
        check("pre-reset num", int'(num), 1);
        check("pre-reset led_clk", int'(led_clk), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset num", int'(num), 0);
        check("async reset led_clk", int'(led_clk), 0);
        check("async reset state", int'(state), 0);
        check("async reset tick", int'(tick), 0);
        exp_led = 1'b0;
        step_edge();
        rst_n = 1'b1;
        repeat (3) step_edge();
        check("post-reset num", int'(num), 0);
        check("post-reset state", int'(state), 0);

        check("scoreboard left", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bin_count_ctrl.md
# bin_count_ctrl

Run/pause/step controller for the LED binary-number display. It owns the tick prescaler and the 4-bit displayed count. It turns debounced button pulses and slide-switch settings into a sequenced count at one of four selectable rates. It also drives the slow toggle output used as the LED "heartbeat".

## Interface
- `TICK_BASE`, default 200000000: clock cycles per tick at speed 0. Must be ≥ 8.
- `PRE_W`, default 28: prescaler width. Must satisfy 2^PRE_W ≥ TICK_BASE.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start_pulse`  in  1  one-cycle pulse from the debouncer: run/resume.
- `stop_pulse`  in  1  one-cycle pulse: pause.
- `step_pulse`  in  1  one-cycle pulse: advance count by one while not running.
- `clear_pulse`  in  1  one-cycle pulse: zero everything, go idle.
- `dir`  in  1  count direction (1 = up, 0 = down). Level input, sampled at each count update.
- `speed`  in  2  rate select. Tick period = TICK_BASE >> speed.
- `num`  out  4  displayed count.
- `tick`  out  1  high for exactly the cycle following each `num` update.
- `led_clk`  out  1  toggles on every `num` update.
- `state`  out  2  current FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 STEP.

## Operation
- Reset (`rst_n` low, async) values: `num`=0, prescaler=0, `tick`=0, `led_clk`=0, `state`=IDLE.
- All outputs are registered. All pulse inputs are sampled at the rising edge of `clk`.
- Command priority when several are asserted in the same cycle: clear > stop > start > step.
- Clear, from any state:
  - `num`=0, prescaler=0, `led_clk`=0, `tick`=0, next state IDLE.
  - Clear is the only command honoured in STEP.
- IDLE:
  - Prescaler held at 0, `num` held.
  - start → RUN.
  - step → count update, then STEP.
  - stop is ignored.
- RUN, at each edge:
  - If stop: go to PAUSE, prescaler frozen, no update, even if the terminal condition holds this cycle.
  - Else if prescaler ≥ period−1: prescaler←0, count update.
  - Else: prescaler+1.
  - start and step are ignored in RUN.
- PAUSE:
  - Prescaler and `num` frozen.
  - start → RUN, resuming from the frozen prescaler value.
  - step → count update, then STEP.
- STEP: lasts one cycle, then unconditionally → PAUSE.
- Count update:
  - `num` ← `num`+1 if `dir`=1, else `num`−1, modulo 16 (15→0 up, 0→15 down).
  - `led_clk` inverts.
  - `tick`=1 for the next cycle. `tick` is 0 in every other cycle.
- Speed:
  - period = TICK_BASE >> `speed`, computed combinationally each cycle.
  - The ≥ comparison makes a mid-count speed change safe: if the prescaler already exceeds the new period−1, the update fires at the next RUN edge.
- Prescaler is PRE_W bits unsigned and never exceeds TICK_BASE−1.

## Timing
- Start sampled at edge E (from IDLE, or from PAUSE with prescaler 0): first update at edge E+period; subsequent updates every period edges.
- Resume from PAUSE with frozen prescaler value p: first update at edge E+(period−1−p)+1.
- Step sampled at edge E: `num` changes and `tick` goes high at E; `state`=STEP during E..E+1; `state`=PAUSE after E+1. A second step is accepted at E+2 at the earliest.
- Stop at edge E leaves `num` unchanged at E, even on a terminal cycle.
- Clear takes effect at the sampling edge. Async reset takes effect immediately.
- Reset deasserting mid-operation: the block restarts in IDLE with all values at their reset values. No partial state survives.

## Test plan
- TICK_BASE=16, speed=0, dir=1, start at edge 0 → `tick` at edges 16, 32, 48; `num` 1, 2, 3; `led_clk` 1, 0, 1.
- Run with speed=2 (period 4) and `num`=15 → next update gives `num`=0. Then dir=0 → next update gives `num`=15.
- Prescaler=10 in RUN at speed 0, switch speed to 3 (period 2) → update on the next edge, then every 2 edges.
- stop coincident with the terminal cycle → `num` unchanged, PAUSE, prescaler frozen at 15. start → update exactly 1 edge later.
- In PAUSE: step, step on consecutive cycles → only the first is honoured (`num`+1, STEP, then PAUSE). step again 2 cycles later → `num`+2 total.
- clear with stop and start asserted in the same cycle while RUN with `num`=9 → `num`=0, `led_clk`=0, IDLE. Async `rst_n` low mid-count → all outputs 0 without waiting for a clock edge.
